// File: rtl/ps2_scan_rx_if.sv
// Key-event stream between the PS/2 receiver and its consumer.
// The receiver drives the show-ahead head entry; the consumer drives ready.
interface ps2_scan_rx_if;
    logic       valid;
    logic       ready;
    logic [7:0] scanCode;
    logic       isBreak;
    logic       isExtended;

    modport master (output valid, scanCode, isBreak, isExtended, input ready);
    modport slave  (input valid, scanCode, isBreak, isExtended, output ready);
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deserialises and checks 11-bit frames, folds E0/F0
// prefixes into flags, tracks the held key and queues events in a show-ahead FIFO.
module ps2_scan_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_scan_rx_if.master evt,
    output logic          frameErr,
    output logic          overflow,
    output logic [7:0]    heldCode,
    output logic          keyDown
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_s3;
    logic          r_dat_s1, r_dat_s2;
    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_sr;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          r_frame_err;
    logic          r_ext_pend, r_brk_pend;
    logic [7:0]    r_held;
    logic          r_key_down;
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [9:0]    r_head;
    logic          r_overflow;

    logic          w_fall, w_d, w_stop, w_par_ok;
    logic          w_timeout, w_frame_ok, w_frame_bad;
    logic          w_push, w_pop, w_full, w_wr;
    logic [9:0]    w_entry, w_head_next;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_cnt_next;

    // Synchronisers idle high so reset never fabricates a falling edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall      = r_clk_s3 & ~r_clk_s2;
    assign w_d         = r_dat_s2;
    assign w_stop      = w_fall && (r_state == STOP);
    assign w_par_ok    = ^{r_sr, r_par};
    assign w_timeout   = (r_state != IDLE) && !w_fall && (r_tmo == TMO_LIMIT);
    assign w_frame_ok  = w_stop && w_d && w_par_ok;
    assign w_frame_bad = (w_stop && !(w_d && w_par_ok)) || w_timeout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bitcnt    <= 3'd0;
            r_tmo       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            if (w_fall || r_state == IDLE)
                r_tmo <= '0;
            else if (r_tmo != TMO_LIMIT)
                r_tmo <= r_tmo + TW'(1);
            if (w_timeout) begin
                r_state <= IDLE;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_d) begin
                            r_state  <= DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY:  r_state <= STOP;
                    STOP:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Shift register and parity capture carry no reset; the FSM qualifies them
    always_ff @(posedge clock) begin
        if (w_fall && r_state == DATA)
            r_sr <= {w_d, r_sr[7:1]};
        if (w_fall && r_state == PARITY)
            r_par <= w_d;
    end

    assign w_push  = w_frame_ok && (r_sr != 8'hE0) && (r_sr != 8'hF0);
    assign w_entry = {r_ext_pend, r_brk_pend, r_sr};

    // Held-key tracking follows every decoded event, even ones the FIFO drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_held     <= 8'h00;
            r_key_down <= 1'b0;
        end else if (w_frame_bad) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_frame_ok) begin
            if (r_sr == 8'hE0) begin
                r_ext_pend <= 1'b1;
            end else if (r_sr == 8'hF0) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
                if (!r_brk_pend) begin
                    r_held     <= r_sr;
                    r_key_down <= 1'b1;
                end else if (r_sr == r_held) begin
                    r_key_down <= 1'b0;
                end
            end
        end
    end

    assign w_pop      = r_valid && evt.ready;
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_rd_next  = r_rd + AW'(w_pop);
    assign w_cnt_next = r_cnt + CW'(w_wr) - CW'(w_pop);
    // The next head may be the entry being written this very cycle
    assign w_head_next = (w_wr && r_wr == w_rd_next) ? w_entry : r_mem[w_rd_next];

    always_ff @(posedge clock) begin
        if (w_wr)
            r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_head     <= 10'd0;
            r_overflow <= 1'b0;
        end else begin
            r_rd       <= w_rd_next;
            r_wr       <= r_wr + AW'(w_wr);
            r_cnt      <= w_cnt_next;
            r_valid    <= (w_cnt_next != '0);
            r_overflow <= w_push && w_full && !w_pop;
            if (w_cnt_next != '0)
                r_head <= w_head_next;
        end
    end

    assign evt.valid      = r_valid;
    assign evt.scanCode   = r_head[7:0];
    assign evt.isBreak    = r_head[8];
    assign evt.isExtended = r_head[9];
    assign frameErr       = r_frame_err;
    assign overflow       = r_overflow;
    assign heldCode       = r_held;
    assign keyDown        = r_key_down;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: drives PS/2 frames on the pins, models the
// expected key events, held key and error/overflow pulses.
module tb_ps2_scan_rx;
    localparam int DEPTH = 8;
    localparam int TMO   = 2000;

    logic       clock;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       frameErr;
    logic       overflow;
    logic [7:0] heldCode;
    logic       keyDown;

    ps2_scan_rx_if evt ();

    ps2_scan_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .evt      (evt),
        .frameErr (frameErr),
        .overflow (overflow),
        .heldCode (heldCode),
        .keyDown  (keyDown)
    );

    int         n_chk = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    int         ovf_cnt = 0;
    int         exp_err = 0;
    int         exp_ovf = 0;
    logic [9:0] q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_held = 8'h00;
    logic       m_down = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse counters: a pulse wider than one cycle counts more than once
    always @(negedge clock) begin
        if (frameErr) err_cnt++;
        if (overflow) ovf_cnt++;
    end

    always @(negedge clock) begin
        if (reset_n && evt.valid && evt.ready) begin
            if (q.size() == 0)
                chk("extra_evt", 32'({evt.isExtended, evt.isBreak, evt.scanCode}), 32'hFFFF_FFFF);
            else
                chk("evt", 32'({evt.isExtended, evt.isBreak, evt.scanCode}), 32'(q.pop_front()));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(4);
        ps2_clk = 1'b0;
        tick(8);
        ps2_clk = 1'b1;
        tick(4);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit flip);
        if (flip) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (q.size() < DEPTH) q.push_back({m_ext, m_brk, d});
            else exp_ovf++;
            if (!m_brk) begin
                m_held = d;
                m_down = 1'b1;
            end else if (d == m_held) begin
                m_down = 1'b0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit lat);
        logic par;
        par = ~(^d) ^ flip;
        model_frame(d, flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_data = 1'b1;
        tick(4);
        ps2_clk = 1'b0;
        if (lat) begin
            repeat (2) @(posedge clock);
            @(negedge clock);
            chk("lat_e", 32'(evt.valid), 32'd0);
            @(posedge clock);
            @(negedge clock);
            chk("lat_e1", 32'(evt.valid), 32'd1);
            tick(5);
        end else begin
            tick(8);
        end
        ps2_clk = 1'b1;
        tick(4);
        chk("held", 32'(heldCode), 32'(m_held));
        chk("down", 32'(keyDown), 32'(m_down));
        chk("ferr_cnt", 32'(err_cnt), 32'(exp_err));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    endtask

    task automatic drain();
        evt.ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!evt.valid) break;
        end
        evt.ready = 1'b0;
        chk("drain_empty", 32'(evt.valid), 32'd0);
        chk("sb_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt.ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(evt.valid), 32'd0);
        chk("rst_code", 32'(evt.scanCode), 32'h00);
        chk("rst_brk", 32'(evt.isBreak), 32'd0);
        chk("rst_ext", 32'(evt.isExtended), 32'd0);
        chk("rst_ferr", 32'(frameErr), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_held", 32'(heldCode), 32'h00);
        chk("rst_down", 32'(keyDown), 32'd0);
        reset_n = 1'b1;
        tick(3);

        // Single make code, latency and single pop
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t1_code", 32'(evt.scanCode), 32'h1C);
        chk("t1_brk", 32'(evt.isBreak), 32'd0);
        chk("t1_ext", 32'(evt.isExtended), 32'd0);
        evt.ready = 1'b1;
        tick(1);
        evt.ready = 1'b0;
        chk("t1_pop", 32'(evt.valid), 32'd0);

        // Make then break of the same key
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Extended break folds into one entry
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("t3_code", 32'(evt.scanCode), 32'h75);
        chk("t3_ext", 32'(evt.isExtended), 32'd1);
        chk("t3_brk", 32'(evt.isBreak), 32'd1);
        drain();

        // Bad parity is rejected, next good frame accepted
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t4_none", 32'(evt.valid), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Partial frame abandoned by timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TMO + 10);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        chk("t5_ferr", 32'(err_cnt), 32'(exp_err));
        send_frame(8'h32, 1'b0, 1'b0);
        chk("t5_code", 32'(evt.scanCode), 32'h32);
        drain();

        // Reset mid-frame discards the queue and partial frame
        send_frame(8'h2B, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        q.delete();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_held = 8'h00;
        m_down = 1'b0;
        tick(2);
        chk("mr_valid", 32'(evt.valid), 32'd0);
        chk("mr_held", 32'(heldCode), 32'h00);
        chk("mr_down", 32'(keyDown), 32'd0);
        reset_n = 1'b1;
        tick(3);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Overflow on the ninth make code only
        for (int k = 1; k <= DEPTH + 1; k++) send_frame(8'(k), 1'b0, 1'b0);
        chk("t6_held", 32'(heldCode), 32'h09);
        chk("t6_ovf", 32'(ovf_cnt), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 keyboard receive front end. Deserialises the raw `ps2_clk`/`ps2_data` line pair into 11-bit frames and checks start, parity and stop bits. Folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags and queues complete key events in a small show-ahead FIFO. Sits directly upstream of the scan-code-to-ASCII translator: `heldCode` feeds the translator's `scanCode` input, and the FIFO port serves event-driven consumers.

## Interface
- `FIFO_DEPTH`, 8, number of queued key events; power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000, clocks without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

- `clock` in 1: single system clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `ready` in 1: consumer pops the head entry when `valid && ready`.
- `valid` out 1: FIFO non-empty.
- `scanCode` out 8: head entry scan code (prefixes stripped).
- `isBreak` out 1: head entry was preceded by 0xF0.
- `isExtended` out 1: head entry was preceded by 0xE0.
- `frameErr` out 1: one-cycle pulse on a bad frame or a timeout.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.
- `heldCode` out 8: last make code received; retained after release.
- `keyDown` out 1: `heldCode` is currently pressed.

## Operation
- **Synchronisation.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A third flop on the clock path generates `fall = prev & ~cur`. Data is sampled from the synchronised `ps2_data` in the cycle where `fall` is high.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on `fall` with data = 0 (start bit), go to DATA and clear the bit count. On `fall` with data = 1, stay in IDLE with no error.
  - DATA: on each `fall`, shift the bit in LSB-first (`sr <= {d, sr[7:1]}`). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good iff data = 1 and `^{sr, parity} == 1` (odd parity). Otherwise pulse `frameErr`. Return to IDLE either way.
- **Timeout.** A counter clears on every `fall` and in IDLE. In any non-IDLE state, reaching `TIMEOUT_CYCLES` forces IDLE and pulses `frameErr`.
- **Byte decode** (good frames only):
  - 0xE0 sets `extPend`.
  - 0xF0 sets `brkPend`.
  - Any other byte pushes `{extPend, brkPend, byte}` to the FIFO and clears both pend flags.
  - A `frameErr` also clears both pend flags.
- **Held key.**
  - A make push (`brkPend` = 0) sets `heldCode <= byte` and `keyDown <= 1`.
  - A break push with byte == `heldCode` sets `keyDown <= 0`.
  - A break for any other code leaves both unchanged.
  - Held-key tracking is independent of FIFO fullness: a dropped event still updates `heldCode`/`keyDown`.
- **FIFO.** Registered head output, show-ahead.
  - Push when full with no pop: the new entry is dropped and `overflow` pulses.
  - Push while full with a same-cycle pop: both happen, count unchanged, no overflow.
  - There is no same-cycle bypass: a push into an empty FIFO is visible next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. The count is `log2(FIFO_DEPTH)+1` bits wide.

## Timing
- **Reset values.** Asynchronous, while `reset_n` = 0:
  - `valid`, `frameErr`, `overflow`, `keyDown`, `isBreak`, `isExtended` = 0.
  - `scanCode` = 0x00, `heldCode` = 0x00.
  - FSM in IDLE, FIFO empty, pend flags clear, synchroniser flops = 1 (idle line).
- **Reset mid-frame.** The partial frame is discarded and the FSM returns to IDLE. Reception restarts at the next start bit after release.
- **Pin to edge.** A falling edge on the `ps2_clk` pin is seen as `fall` 2–3 clocks later.
- **Event latency.** Let E be the cycle in which the stop-bit `fall` is detected:
  - cycle E+1: `valid`, `heldCode` and `keyDown` update;
  - cycle E+1: `frameErr` or `overflow` pulses high for exactly that cycle.
- **Pop.** `valid && ready` at edge N: the next entry, or `valid` = 0, appears at N+1.
- `frameErr` and `overflow` never stay high for more than one cycle per event.
- **Clock ratio.** `clock` must be ≥ 8× the PS/2 clock (PS/2 ≤ 16.7 kHz).

## Test plan
1. Frame 0x1C with parity 0, `ready` = 0 → `valid` = 1 at E+1; `scanCode` = 0x1C, `isBreak` = 0, `isExtended` = 0, `heldCode` = 0x1C, `keyDown` = 1. Pulse `ready` once → `valid` = 0 next cycle.
2. Frames 0x1C, 0xF0, 0x1C → two entries, (0x1C, brk 0) then (0x1C, brk 1). `keyDown` = 0 after the third frame; `heldCode` stays 0x1C.
3. Frames 0xE0, 0xF0, 0x75 → exactly one entry: `scanCode` = 0x75, `isExtended` = 1, `isBreak` = 1.
4. Frame 0x1C with parity bit flipped → `frameErr` pulses one cycle; no entry pushed; `keyDown` unchanged. A following good 0x1C is accepted.
5. Start bit plus 4 data bits, then the line idles for `TIMEOUT_CYCLES` + 10 clocks → one `frameErr` pulse and FSM in IDLE. A subsequent good 0x32 frame yields `scanCode` = 0x32.
6. `FIFO_DEPTH` + 1 make codes 0x01…0x09 with `ready` = 0 → `overflow` pulses on the 9th only; `heldCode` = 0x09. Drain returns 0x01…0x08 in order, then `valid` = 0.
